ifu: RTL and testbench

- Instruction-fetch stage of the 5-stage LoongArch pipeline.
- Generates the next PC (pre-IF), issues requests to the synchronous instruction SRAM, and holds the fetched instruction.
- Delivers {pc, inst} to the decode stage under a valid/ready handshake.
- Applies branch redirects returned by decode and discards wrong-path fetches.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/if_inst_buf.sv | 59 +++++
 rtl/ifu.sv | 114 +++++++++++
 tb/tb_ifu.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants for the instruction-fetch stage.
//   PC_W / INST_W     : address and instruction widths
//   RESET_PC_DEFAULT  : first fetch address after reset
//   PC_STEP           : sequential PC increment
//   NOP_INST          : LoongArch NOP (andi r0,r0,0), handy as a fill word
//   seq_pc()          : sequential next-PC helper (wraps modulo 2^32)
package ifu_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0]   RESET_PC_DEFAULT = 32'h1C00_0000;
    localparam logic [PC_W-1:0]   PC_STEP          = 32'h0000_0004;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0340_0000;

    function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// if_inst_buf: holds the fetched word while decode is stalled.
// The SRAM read data is only valid in the cycle right after the request, so
// the first stall cycle copies it into a local buffer; later stall cycles
// deliver the buffered copy regardless of what the SRAM output does.
//   clk, rst  : clock, asynchronous active-high reset
//   fs_valid  : IF holds a live instruction
//   id_ready  : decode accepts this cycle
//   issue     : a new fetch is issued this cycle (buffer no longer relevant)
//   rdata     : SRAM read data
//   inst      : instruction word presented to decode
module if_inst_buf
    import ifu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fs_valid,
    input  logic              id_ready,
    input  logic              issue,
    input  logic [INST_W-1:0] rdata,
    output logic [INST_W-1:0] inst
);

    logic              buf_valid_r;
    logic [INST_W-1:0] inst_buf_r;
    logic              capture_s;

    // Capture only once per fetched word: the SRAM data is fresh only while the buffer is empty.
    assign capture_s = fs_valid & ~buf_valid_r & ~id_ready;

    // Buffer register: cleared by each new issue, loaded on the first stall cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_r <= 1'b0;
            inst_buf_r  <= {INST_W{1'b0}};
        end else if (issue) begin
            buf_valid_r <= 1'b0;
            inst_buf_r  <= inst_buf_r;
        end else if (capture_s) begin
            buf_valid_r <= 1'b1;
            inst_buf_r  <= rdata;
        end else begin
            buf_valid_r <= buf_valid_r;
            inst_buf_r  <= inst_buf_r;
        end
    end

    // Output mux; an empty stage presents zero so the reset value is deterministic.
    always_comb begin
        inst = {INST_W{1'b0}};
        if (buf_valid_r) begin
            inst = inst_buf_r;
        end else if (fs_valid) begin
            inst = rdata;
        end else begin
            inst = {INST_W{1'b0}};
        end
    end

endmodule

// File: rtl/ifu.sv
// ifu: instruction-fetch stage of the 5-stage LoongArch pipeline.
// Computes the next PC, issues requests to the synchronous instruction SRAM
// (data returns one cycle later), and hands {pc, inst} to decode under a
// valid/ready handshake. Taken branches from decode kill the wrong-path
// instruction in IF; a redirect that cannot be issued immediately is parked
// in a pending register until IF can accept a new fetch.
//   clk, rst         : clock, asynchronous active-high reset
//   inst_sram_*      : SRAM request (en, addr) and read data
//   i_id_ready       : decode can accept
//   if_to_id_*       : valid, pc, inst towards decode
//   br_taken/stall   : decode branch outcome; stall means outcome not trustworthy
//   br_target        : redirect target
module ifu
    import ifu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              inst_sram_en,
    output logic [PC_W-1:0]   inst_sram_addr,
    input  logic [INST_W-1:0] inst_sram_rdata,
    input  logic              i_id_ready,
    output logic              if_to_id_valid,
    output logic [PC_W-1:0]   if_to_id_pc,
    output logic [INST_W-1:0] if_to_id_inst,
    input  logic              br_taken,
    input  logic              br_stall,
    input  logic [PC_W-1:0]   br_target
);

    logic            rst_q_r;
    logic            fs_valid_r;
    logic [PC_W-1:0] fs_pc_r;
    logic            br_pend_r;
    logic [PC_W-1:0] br_pend_target_r;

    logic            redirect_s;
    logic            fs_allowin_s;
    logic            issue_s;
    logic            xfer_s;
    logic [PC_W-1:0] nextpc_s;

    assign redirect_s   = br_taken & ~br_stall;
    assign fs_allowin_s = ~fs_valid_r | i_id_ready;
    assign issue_s      = ~rst_q_r & fs_allowin_s & ~(redirect_s & fs_valid_r & ~i_id_ready);
    assign xfer_s       = if_to_id_valid & i_id_ready;

    // Next-PC select: a live redirect beats a parked one, which beats sequential flow.
    always_comb begin
        nextpc_s = seq_pc(fs_pc_r);
        if (redirect_s) begin
            nextpc_s = br_target;
        end else if (br_pend_r) begin
            nextpc_s = br_pend_target_r;
        end else begin
            nextpc_s = seq_pc(fs_pc_r);
        end
    end

    assign inst_sram_en   = issue_s;
    assign inst_sram_addr = nextpc_s;
    assign if_to_id_valid = fs_valid_r & ~redirect_s;
    assign if_to_id_pc    = fs_pc_r;

    // Fetch-stage state: post-reset hold-off, PC/valid tracking and the parked redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q_r          <= 1'b1;
            fs_valid_r       <= 1'b0;
            fs_pc_r          <= RESET_PC - PC_STEP;
            br_pend_r        <= 1'b0;
            br_pend_target_r <= {PC_W{1'b0}};
        end else begin
            rst_q_r <= 1'b0;

            if (issue_s) begin
                fs_pc_r    <= nextpc_s;
                fs_valid_r <= 1'b1;
            end else if (xfer_s | redirect_s) begin
                // Delivered, or wrong-path and killed.
                fs_pc_r    <= fs_pc_r;
                fs_valid_r <= 1'b0;
            end else begin
                fs_pc_r    <= fs_pc_r;
                fs_valid_r <= fs_valid_r;
            end

            // Any issue consumes the parked target: either it was the issued
            // address, or a newer redirect superseded it.
            if (issue_s) begin
                br_pend_r        <= 1'b0;
                br_pend_target_r <= br_pend_target_r;
            end else if (redirect_s) begin
                br_pend_r        <= 1'b1;
                br_pend_target_r <= br_target;
            end else begin
                br_pend_r        <= br_pend_r;
                br_pend_target_r <= br_pend_target_r;
            end
        end
    end

    if_inst_buf u_inst_buf (
        .clk      (clk),
        .rst      (rst),
        .fs_valid (fs_valid_r),
        .id_ready (i_id_ready),
        .issue    (issue_s),
        .rdata    (inst_sram_rdata),
        .inst     (if_to_id_inst)
    );

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed bench for ifu. The stimulus process pushes expected
// {pc, inst} transfers into a scoreboard queue and records per-cycle
// expectations for the fetch request and output valid; a monitor process
// checks everything on the falling edge.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] R = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        i_id_ready = 1'b1;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_pc;
    logic [31:0] if_to_id_inst;
    logic        br_taken = 1'b0;
    logic        br_stall = 1'b0;
    logic [31:0] br_target = 32'h0;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(R)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .i_id_ready      (i_id_ready),
        .if_to_id_valid  (if_to_id_valid),
        .if_to_id_pc     (if_to_id_pc),
        .if_to_id_inst   (if_to_id_inst),
        .br_taken        (br_taken),
        .br_stall        (br_stall),
        .br_target       (br_target)
    );

    // SRAM model: returns the requested address as data; corrupt overrides the output.
    logic [31:0] sram_q = NOP_INST;
    logic        corrupt = 1'b0;
    always @(posedge clk) if (inst_sram_en) sram_q <= inst_sram_addr;
    assign inst_sram_rdata = corrupt ? 32'hDEAD_BEEF : sram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          chk_en;
        bit          en;
        bit          chk_addr;
        logic [31:0] addr;
        bit          chk_valid;
        bit          valid;
        bit          chk_data;
        logic [31:0] pc;
        logic [31:0] inst;
    } ctl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } xfer_t;

    ctl_t  ctl_exp [256];
    xfer_t exp_q [$];
    bit    done = 1'b0;
    int    pass_cnt = 0;
    int    total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic step(input bit rdy, input bit bt, input bit bs, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        i_id_ready = rdy;
        br_taken   = bt;
        br_stall   = bs;
        br_target  = tgt;
    endtask

    task automatic exp_fetch(input bit en, input logic [31:0] addr);
        ctl_exp[cyc].chk_en   = 1'b1;
        ctl_exp[cyc].en       = en;
        ctl_exp[cyc].chk_addr = en;
        ctl_exp[cyc].addr     = addr;
    endtask

    task automatic exp_out(input bit v, input bit chk_data, input logic [31:0] pc, input logic [31:0] inst);
        ctl_exp[cyc].chk_valid = 1'b1;
        ctl_exp[cyc].valid     = v;
        ctl_exp[cyc].chk_data  = chk_data;
        ctl_exp[cyc].pc        = pc;
        ctl_exp[cyc].inst      = inst;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    // Stimulus
    initial begin
        // 1: reset release, sequential fetch
        push(R, R); push(R + 32'h4, R + 32'h4); push(R + 32'h8, R + 32'h8);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        exp_fetch(1'b0, 32'h0); exp_out(1'b0, 1'b1, R - 32'h4, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0); rst = 1'b0;
        exp_fetch(1'b0, 32'h0); exp_out(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R);          exp_out(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R + 32'h4);  exp_out(1'b1, 1'b1, R, R);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R + 32'h8);  exp_out(1'b1, 1'b1, R + 32'h4, R + 32'h4);
        // 2: five-cycle stall on R+8 with SRAM output corrupted
        step(1'b0, 1'b0, 1'b0, 32'h0); exp_fetch(1'b0, 32'h0); exp_out(1'b1, 1'b1, R + 32'h8, R + 32'h8);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0); corrupt = 1'b1;
            exp_fetch(1'b0, 32'h0); exp_out(1'b1, 1'b1, R + 32'h8, R + 32'h8);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0); corrupt = 1'b0;
        exp_fetch(1'b1, R + 32'hC); exp_out(1'b1, 1'b1, R + 32'h8, R + 32'h8);
        // 3: redirect with decode ready; R+C is killed
        push(R + 32'h100, R + 32'h100); push(R + 32'h104, R + 32'h104);
        step(1'b1, 1'b1, 1'b0, R + 32'h100); exp_fetch(1'b1, R + 32'h100); exp_out(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R + 32'h104); exp_out(1'b1, 1'b1, R + 32'h100, R + 32'h100);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R + 32'h108); exp_out(1'b1, 1'b1, R + 32'h104, R + 32'h104);
        // 4: redirect while decode stalled -> parked, issued on next allowin cycle
        push(R + 32'h200, R + 32'h200);
        step(1'b0, 1'b1, 1'b0, R + 32'h200); exp_fetch(1'b0, 32'h0); exp_out(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R + 32'h200); exp_out(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R + 32'h204); exp_out(1'b1, 1'b1, R + 32'h200, R + 32'h200);
        // 5: br_taken with br_stall is ignored
        push(R + 32'h204, R + 32'h204); push(R + 32'h208, R + 32'h208);
        step(1'b1, 1'b1, 1'b1, R + 32'h300); exp_fetch(1'b1, R + 32'h208); exp_out(1'b1, 1'b1, R + 32'h204, R + 32'h204);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R + 32'h20C); exp_out(1'b1, 1'b1, R + 32'h208, R + 32'h208);
        // 6: park a redirect, then reset asynchronously while it is pending
        step(1'b0, 1'b1, 1'b0, R + 32'h400); exp_fetch(1'b0, 32'h0); exp_out(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0); rst = 1'b1;
        exp_fetch(1'b0, 32'h0); exp_out(1'b0, 1'b1, R - 32'h4, 32'h0);
        push(R, R); push(R + 32'h4, R + 32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0); rst = 1'b0;
        exp_fetch(1'b0, 32'h0); exp_out(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R);         exp_out(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R + 32'h4); exp_out(1'b1, 1'b1, R, R);
        step(1'b1, 1'b0, 1'b0, 32'h0); exp_fetch(1'b1, R + 32'h8); exp_out(1'b1, 1'b1, R + 32'h4, R + 32'h4);
        // async reset with a live instruction in IF
        step(1'b1, 1'b0, 1'b0, 32'h0); rst = 1'b1;
        exp_fetch(1'b0, 32'h0); exp_out(1'b0, 1'b1, R - 32'h4, 32'h0);
        done = 1'b1;
    end

    // Monitor: per-cycle control checks plus scoreboard of delivered instructions
    initial begin : monitor
        ctl_t  c;
        xfer_t e;
        forever begin
            @(negedge clk);
            if (cyc < 256) begin
                c = ctl_exp[cyc];
                if (c.chk_en)    chk("sram_en", {31'h0, inst_sram_en}, {31'h0, c.en});
                if (c.chk_addr)  chk("sram_addr", inst_sram_addr, c.addr);
                if (c.chk_valid) chk("valid", {31'h0, if_to_id_valid}, {31'h0, c.valid});
                if (c.chk_data) begin
                    chk("out_pc", if_to_id_pc, c.pc);
                    chk("out_inst", if_to_id_inst, c.inst);
                end
            end
            if (if_to_id_valid && i_id_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_xfer cycle %0d: got pc %h expected none", cyc, if_to_id_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_pc", if_to_id_pc, e.pc);
                    chk("xfer_inst", if_to_id_inst, e.inst);
                end
            end
            if (done || cyc > 500) begin
                if (!done) begin
                    total_cnt++;
                    $display("FAIL timeout cycle %0d: got no end of stimulus, expected done", cyc);
                end
                chk("sb_empty", exp_q.size(), 32'h0);
                $display("%0d/%0d checks passed", pass_cnt, total_cnt);
                $finish;
            end
        end
    end

endmodule
